// File: rtl/caf_peak_search_if.sv
// Row-result input and frame-record output bundle for the CAF peak search.
// The slave modport is the peak-search block; the master modport is the
// surrounding pipeline (row producer plus frame consumer).
interface caf_peak_search_if #(
  parameter int unsigned freq_bits   = 3,
  parameter int unsigned index_bits  = 4,
  parameter int unsigned in_max_bits = 4
);
  // Row results coming from the per-row arg-max stage.
  logic                   m_axis_tvalid;
  logic [in_max_bits-1:0] in_max;
  logic [index_bits:0]    in_index;
  logic                   s_axis_tready;

  // Detection threshold, sampled when a frame record is emitted.
  logic [in_max_bits-1:0] threshold;

  // Frame records going to the consumer.
  logic                   m_axis_tready;
  logic                   s_axis_tvalid;
  logic [in_max_bits-1:0] peak_max;
  logic [index_bits:0]    peak_index;
  logic [freq_bits-1:0]   peak_freq;
  logic                   detect;

  modport slave (
    input  m_axis_tvalid, in_max, in_index, threshold, m_axis_tready,
    output s_axis_tready, s_axis_tvalid, peak_max, peak_index, peak_freq, detect
  );

  modport master (
    output m_axis_tvalid, in_max, in_index, threshold, m_axis_tready,
    input  s_axis_tready, s_axis_tvalid, peak_max, peak_index, peak_freq, detect
  );
endinterface

// File: rtl/caf_peak_search.sv
// Global CAF peak tracker: folds one (magnitude, time index) row result per
// frequency bin into a running best, then emits one (peak, time index,
// frequency index, detect) record per frame and holds it until accepted.
module caf_peak_search #(
  parameter int unsigned num_freqs   = 8,
  parameter int unsigned freq_bits   = 3,
  parameter int unsigned index_bits  = 4,
  parameter int unsigned in_max_bits = 4
) (
  input  logic              clk,
  input  logic              rst,
  caf_peak_search_if.slave  bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  localparam logic [freq_bits-1:0] ROW_LAST = freq_bits'(num_freqs - 1);

  state_t                 state_q;
  state_t                 state_d;

  logic [freq_bits-1:0]   row_q;
  logic [in_max_bits-1:0] best_max_q;
  logic [index_bits:0]    best_index_q;
  logic [freq_bits-1:0]   best_freq_q;

  logic                   tready_q;
  logic                   tvalid_q;
  logic [in_max_bits-1:0] peak_max_q;
  logic [index_bits:0]    peak_index_q;
  logic [freq_bits-1:0]   peak_freq_q;
  logic                   detect_q;

  logic                   row_accept;
  logic                   row_is_last;
  logic                   take_row;
  logic                   rec_accept;
  logic [in_max_bits-1:0] cand_max;
  logic [index_bits:0]    cand_index;
  logic [freq_bits-1:0]   cand_freq;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the candidate best after folding in the current row.
  always_comb begin
    state_d     = state_q;
    row_accept  = 1'b0;
    rec_accept  = 1'b0;
    row_is_last = (row_q == ROW_LAST);
    // Row 0 always seeds the best; later rows must be strictly larger so
    // that ties keep the earlier row.
    take_row    = (row_q == '0) || (bus.in_max > best_max_q);
    cand_max    = best_max_q;
    cand_index  = best_index_q;
    cand_freq   = best_freq_q;

    if (take_row) begin
      cand_max   = bus.in_max;
      cand_index = bus.in_index;
      cand_freq  = row_q;
    end

    unique case (state_q)
      ACCUM: begin
        row_accept = bus.m_axis_tvalid & tready_q;
        if (row_accept && row_is_last) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        rec_accept = tvalid_q & bus.m_axis_tready;
        if (rec_accept) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Row counter and running best.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q        <= '0;
      best_max_q   <= '0;
      best_index_q <= '0;
      best_freq_q  <= '0;
    end else if (row_accept) begin
      best_max_q   <= cand_max;
      best_index_q <= cand_index;
      best_freq_q  <= cand_freq;
      row_q        <= row_is_last ? '0 : row_q + 1'b1;
    end
  end

  // Handshake flags are registered from the next state, so tready is low in
  // the cycle right after the last row accept and stays low through EMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      tready_q <= (state_d == ACCUM);
      tvalid_q <= (state_d == EMIT);
    end
  end

  // Frame record: loaded on the last row accept, including that row if it
  // wins; held through EMIT and after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_max_q   <= '0;
      peak_index_q <= '0;
      peak_freq_q  <= '0;
      detect_q     <= 1'b0;
    end else if (row_accept && row_is_last) begin
      peak_max_q   <= cand_max;
      peak_index_q <= cand_index;
      peak_freq_q  <= cand_freq;
      detect_q     <= (cand_max >= bus.threshold);
    end
  end

  assign bus.s_axis_tready = tready_q;
  assign bus.s_axis_tvalid = tvalid_q;
  assign bus.peak_max      = peak_max_q;
  assign bus.peak_index    = peak_index_q;
  assign bus.peak_freq     = peak_freq_q;
  assign bus.detect        = detect_q;

endmodule
